// File: rtl/mem_1rw_arbiter.sv
// Shares one 1RW SRAM macro between NUM_RD read requesters and one writer,
// with starvation-bounded write priority and a 2-stage tagged read-return pipe.
module mem_1rw_arbiter #(
  parameter  int WORD_SIZE  = 256,
  parameter  int NUM_WORDS  = 128,
  parameter  int WRITE_SIZE = 8,
  parameter  int NUM_RD     = 2,
  parameter  int WR_STARVE  = 4,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int MW = WORD_SIZE / WRITE_SIZE,
  localparam int IW = $clog2(NUM_RD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 IN_flush,
  input  logic                 IN_wr_valid,
  output logic                 OUT_wr_ready,
  input  logic [AW-1:0]        IN_wr_addr,
  input  logic [WORD_SIZE-1:0] IN_wr_data,
  input  logic [MW-1:0]        IN_wr_wm,
  input  logic [NUM_RD-1:0]    IN_rd_valid,
  output logic [NUM_RD-1:0]    OUT_rd_ready,
  input  logic [NUM_RD*AW-1:0] IN_rd_addr,
  output logic                 OUT_rd_rvalid,
  output logic [IW-1:0]        OUT_rd_rid,
  output logic [WORD_SIZE-1:0] OUT_rd_data,
  output logic                 OUT_mem_nce,
  output logic                 OUT_mem_nwe,
  output logic [AW-1:0]        OUT_mem_addr,
  output logic [WORD_SIZE-1:0] OUT_mem_data,
  output logic [MW-1:0]        OUT_mem_wm,
  input  logic [WORD_SIZE-1:0] IN_mem_data
);

  localparam int SW = $clog2(WR_STARVE + 1);

  logic [SW-1:0] starve_cnt;
  logic [IW-1:0] rr_ptr;
  logic          s0_valid, s1_valid;
  logic [IW-1:0] s0_rid, s1_rid;

  logic          wr_grant, rd_grant, found;
  logic [IW-1:0] sel;
  int            idx;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    // Round-robin search starting at rr_ptr, wrapping at NUM_RD.
    for (int k = 0; k < NUM_RD; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_RD) idx = idx - NUM_RD;
      if (!found && IN_rd_valid[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
    wr_grant = rst_n && IN_wr_valid &&
               (!(|IN_rd_valid) || starve_cnt == SW'(WR_STARVE));
    rd_grant = rst_n && found && !wr_grant;
  end

  always_comb begin
    OUT_wr_ready = wr_grant;
    OUT_rd_ready = rd_grant ? (NUM_RD'(1) << sel) : '0;
    OUT_mem_nce  = 1'b1;
    OUT_mem_nwe  = 1'b1;
    OUT_mem_addr = '0;
    OUT_mem_data = '0;
    OUT_mem_wm   = '0;
    if (wr_grant) begin
      OUT_mem_nce  = 1'b0;
      OUT_mem_nwe  = 1'b0;
      OUT_mem_addr = IN_wr_addr;
      OUT_mem_data = IN_wr_data;
      OUT_mem_wm   = IN_wr_wm;
    end else if (rd_grant) begin
      OUT_mem_nce  = 1'b0;
      OUT_mem_addr = IN_rd_addr[sel*AW +: AW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      rr_ptr     <= '0;
    end else begin
      if (wr_grant)
        starve_cnt <= '0;
      else if (IN_wr_valid && starve_cnt != SW'(WR_STARVE))
        starve_cnt <= starve_cnt + 1'b1;
      if (rd_grant)
        rr_ptr <= (sel == IW'(NUM_RD - 1)) ? '0 : sel + 1'b1;
    end
  end

  // Flush kills both stages; a read granted in the flush cycle never enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s0_rid   <= '0;
      s1_rid   <= '0;
    end else begin
      s0_valid <= rd_grant && !IN_flush;
      s0_rid   <= rd_grant ? sel : '0;
      s1_valid <= s0_valid && !IN_flush;
      s1_rid   <= s0_rid;
    end
  end

  assign OUT_rd_rvalid = s1_valid;
  assign OUT_rd_rid    = s1_rid;
  assign OUT_rd_data   = IN_mem_data;

endmodule
